// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the raster timing outputs of vga_timing_gen so that the
//   image-fetch and pixel-output stages can take them as a single port.
//
//   master : driven by the timing generator
//   slave  : consumed by downstream stages
//
//   hsync, vsync  sync pulses at the configured polarity
//   active        current pixel is visible
//   x, y          horizontal / vertical raster position
//   line_start    one-cycle strobe at x==0
//   frame_start   one-cycle strobe at x==0, y==0
//   running       generator is in its RUN state
interface vga_timing_gen_if;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [10:0] x;
  logic [10:0] y;
  logic        line_start;
  logic        frame_start;
  logic        running;

  modport master (
    output hsync, vsync, active, x, y, line_start, frame_start, running
  );

  modport slave (
    input hsync, vsync, active, x, y, line_start, frame_start, running
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator running on the pixel-clock PLL output. It stays
//   idle until the synchronized PLL lock flag has been high for LOCK_WAIT
//   consecutive cycles, then produces sync pulses, the active-video
//   qualifier, pixel coordinates and line/frame strobes. Losing lock drops
//   straight back to idle; a new lock always restarts at the frame origin.
//
//   clk         pixel clock (PLL output)
//   rst         synchronous active-high reset
//   pll_locked  PLL lock flag, asynchronous to clk
//   vga         timing outputs (master side of vga_timing_gen_if)
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int LOCK_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Decode thresholds are one bit wider so a 2048-wide region still compares correctly
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYN_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYN_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYN_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYN_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             lockMeta_q, lockSync_q;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             lineStart_q, lineStart_d;
  logic             frameStart_q, frameStart_d;
  logic             running_q, running_d;
  logic             lk;
  logic [11:0]      xExt, yExt;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
    end else begin
      lockMeta_q <= pll_locked;
      lockSync_q <= lockMeta_q;
    end
  end

  assign lk = lockSync_q;

  // Next-state logic; counters fall to zero in every non-RUN path so the
  // first RUN cycle always presents the frame origin
  always_comb begin
    state_d     = state_q;
    settleCnt_d = '0;
    x_d         = '0;
    y_d         = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (settleCnt_q == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settleCnt_d = settleCnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (x_q == H_LAST) begin
          y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
        end else begin
          x_d = x_q + 11'd1;
          y_d = y_q;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output decode works on the next-state values so the registered outputs
  // line up with the registered x/y of the same cycle
  assign xExt = {1'b0, x_d};
  assign yExt = {1'b0, y_d};

  always_comb begin
    running_d    = (state_d == RUN);
    active_d     = running_d && (xExt < H_ACT_END) && (yExt < V_ACT_END);
    hsync_d      = (running_d && (xExt >= H_SYN_BEG) && (xExt < H_SYN_END)) ? SYNC_ON : SYNC_OFF;
    vsync_d      = (running_d && (yExt >= V_SYN_BEG) && (yExt < V_SYN_END)) ? SYNC_ON : SYNC_OFF;
    lineStart_d  = running_d && (x_d == 11'd0);
    frameStart_d = lineStart_d && (y_d == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      settleCnt_q  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= SYNC_OFF;
      vsync_q      <= SYNC_OFF;
      active_q     <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
      running_q    <= running_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.active      = active_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = lineStart_q;
  assign vga.frame_start = frameStart_q;
  assign vga.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. One instance uses the default 640x480
//   timing (lock latency, glitch, unlock, mid-frame reset, one full line);
//   a second uses a tiny 14x7 raster with SYNC_POL=1 so whole frames fit.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic lockDef;
  logic lockSmall;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen_if vgaDef ();
  vga_timing_gen_if vgaSmall ();

  vga_timing_gen dutDef (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (lockDef),
    .vga        (vgaDef)
  );

  vga_timing_gen #(
    .H_ACTIVE  (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (1),
    .V_ACTIVE  (4),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .SYNC_POL  (1),
    .LOCK_WAIT (4)
  ) dutSmall (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (lockSmall),
    .vga        (vgaSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstVal, input logic lockDefVal, input logic lockSmallVal);
    rst       = rstVal;
    lockDef   = lockDefVal;
    lockSmall = lockSmallVal;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Idle/reset values for the default (active-low sync) instance
  task automatic checkDefIdle(input string tag);
    checkOutput({tag, "_running"}, int'(vgaDef.running), 0);
    checkOutput({tag, "_x"}, int'(vgaDef.x), 0);
    checkOutput({tag, "_y"}, int'(vgaDef.y), 0);
    checkOutput({tag, "_hsync"}, int'(vgaDef.hsync), 1);
    checkOutput({tag, "_vsync"}, int'(vgaDef.vsync), 1);
    checkOutput({tag, "_active"}, int'(vgaDef.active), 0);
    checkOutput({tag, "_linestart"}, int'(vgaDef.line_start), 0);
    checkOutput({tag, "_framestart"}, int'(vgaDef.frame_start), 0);
  endtask

  // Counts cycles until running rises; gives up at limit
  task automatic waitRun(input bit useSmall, input int limit, output int lat);
    lat = 0;
    while (((useSmall ? vgaSmall.running : vgaDef.running) !== 1'b1) && (lat < limit)) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int hsCnt, hsFirst, hsLast, actCnt, xErr;
    int mx, my;
    int lsCnt, fsCnt, vsCnt, xyErr, hsErr, vsErr, actErr, lsErr, fsErr;
    logic expH, expV, expA;

    // Reset with lock already present on the default instance
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checkDefIdle("reset");
    checkOutput("reset_small_hsync", int'(vgaSmall.hsync), 0);
    checkOutput("reset_small_vsync", int'(vgaSmall.vsync), 0);
    checkOutput("reset_small_running", int'(vgaSmall.running), 0);

    // Release reset: running first high LOCK_WAIT+3 = 19 cycles later
    $display("[TB] lock latency after reset release");
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRun(1'b0, 40, lat);
    checkOutput("lock_latency", lat, 19);
    checkOutput("first_framestart", int'(vgaDef.frame_start), 1);
    checkOutput("first_linestart", int'(vgaDef.line_start), 1);
    checkOutput("first_active", int'(vgaDef.active), 1);
    checkOutput("first_x", int'(vgaDef.x), 0);
    checkOutput("first_y", int'(vgaDef.y), 0);
    checkOutput("first_hsync", int'(vgaDef.hsync), 1);
    checkOutput("first_vsync", int'(vgaDef.vsync), 1);

    // One full line: 96 low hsync cycles at x=656..751, 640 active
    $display("[TB] first line decode");
    hsCnt = 0; hsFirst = -1; hsLast = -1; actCnt = 0; xErr = 0;
    for (int i = 0; i < 800; i++) begin
      if (vgaDef.hsync === 1'b0) begin
        hsCnt++;
        if (hsFirst < 0) hsFirst = int'(vgaDef.x);
        hsLast = int'(vgaDef.x);
      end
      if (vgaDef.active === 1'b1) actCnt++;
      if (int'(vgaDef.x) != i) xErr++;
      tick();
    end
    checkOutput("line_hsync_cycles", hsCnt, 96);
    checkOutput("line_hsync_first_x", hsFirst, 656);
    checkOutput("line_hsync_last_x", hsLast, 751);
    checkOutput("line_active_cycles", actCnt, 640);
    checkOutput("line_x_sequence_errors", xErr, 0);
    checkOutput("line_wrap_x", int'(vgaDef.x), 0);
    checkOutput("line_wrap_y", int'(vgaDef.y), 1);
    checkOutput("line_wrap_linestart", int'(vgaDef.line_start), 1);
    checkOutput("line_wrap_framestart", int'(vgaDef.frame_start), 0);

    // Drop lock at x=300, y=2; outputs idle three cycles later
    $display("[TB] lock loss mid-frame");
    repeat (1100) tick();
    checkOutput("unlock_pos_x", int'(vgaDef.x), 300);
    checkOutput("unlock_pos_y", int'(vgaDef.y), 2);
    checkOutput("unlock_pos_vsync", int'(vgaDef.vsync), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("unlock_c2_running", int'(vgaDef.running), 1);
    checkOutput("unlock_c2_x", int'(vgaDef.x), 302);
    tick();
    checkDefIdle("unlock_c3");

    // Relock restarts at the frame origin
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRun(1'b0, 40, lat);
    checkOutput("relock_latency", lat, 19);
    checkOutput("relock_framestart", int'(vgaDef.frame_start), 1);
    checkOutput("relock_x", int'(vgaDef.x), 0);
    checkOutput("relock_y", int'(vgaDef.y), 0);

    // One-cycle lock glitch at settle count 10 restarts the settle period
    $display("[TB] lock glitch during settle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("glitch_idle_running", int'(vgaDef.running), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (13) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRun(1'b0, 60, lat);
    checkOutput("glitch_latency", lat, 19);
    checkOutput("glitch_framestart", int'(vgaDef.frame_start), 1);

    // Reset mid-frame at y=3
    $display("[TB] reset mid-frame");
    repeat (3 * 800 + 100) tick();
    checkOutput("midrst_pos_x", int'(vgaDef.x), 100);
    checkOutput("midrst_pos_y", int'(vgaDef.y), 3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkDefIdle("midrst");
    checkOutput("midrst_small_hsync", int'(vgaSmall.hsync), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRun(1'b0, 40, lat);
    checkOutput("midrst_relock_latency", lat, 19);
    checkOutput("midrst_relock_framestart", int'(vgaDef.frame_start), 1);

    // Small raster, active-high syncs: lock latency 2+4+1 then two frames
    $display("[TB] small raster two frames");
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitRun(1'b1, 30, lat);
    checkOutput("small_lock_latency", lat, 7);
    mx = 0; my = 0;
    lsCnt = 0; fsCnt = 0; vsCnt = 0; hsCnt = 0; actCnt = 0;
    xyErr = 0; hsErr = 0; vsErr = 0; actErr = 0; lsErr = 0; fsErr = 0;
    for (int i = 0; i < 196; i++) begin
      expH = (mx >= 10) && (mx <= 12);
      expV = (my == 5);
      expA = (mx < 8) && (my < 4);
      if ((int'(vgaSmall.x) != mx) || (int'(vgaSmall.y) != my)) xyErr++;
      if (vgaSmall.hsync !== expH) hsErr++;
      if (vgaSmall.vsync !== expV) vsErr++;
      if (vgaSmall.active !== expA) actErr++;
      if (vgaSmall.line_start !== (mx == 0)) lsErr++;
      if (vgaSmall.frame_start !== ((mx == 0) && (my == 0))) fsErr++;
      if (vgaSmall.hsync === 1'b1) hsCnt++;
      if (vgaSmall.vsync === 1'b1) vsCnt++;
      if (vgaSmall.active === 1'b1) actCnt++;
      if (vgaSmall.line_start === 1'b1) lsCnt++;
      if (vgaSmall.frame_start === 1'b1) fsCnt++;
      if (mx == 13) begin
        mx = 0;
        my = (my == 6) ? 0 : my + 1;
      end else begin
        mx++;
      end
      tick();
    end
    checkOutput("small_xy_errors", xyErr, 0);
    checkOutput("small_hsync_errors", hsErr, 0);
    checkOutput("small_vsync_errors", vsErr, 0);
    checkOutput("small_active_errors", actErr, 0);
    checkOutput("small_linestart_errors", lsErr, 0);
    checkOutput("small_framestart_errors", fsErr, 0);
    checkOutput("small_hsync_cycles", hsCnt, 42);
    checkOutput("small_vsync_cycles", vsCnt, 28);
    checkOutput("small_active_cycles", actCnt, 64);
    checkOutput("small_linestart_count", lsCnt, 14);
    checkOutput("small_framestart_count", fsCnt, 2);
    checkOutput("small_frame_period_fs", int'(vgaSmall.frame_start), 1);
    checkOutput("small_frame_period_x", int'(vgaSmall.x), 0);
    checkOutput("small_frame_period_y", int'(vgaSmall.y), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
